// File: rtl/cprv_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : cprv_pkg
//  Description : Shared definitions for the cprv writeback/commit stage.
//                - RV64I major opcodes
//                - load funct3 encodings
//                - writeback state type
//  Revision    : 1.0 - initial release
// ============================================================================
package cprv_pkg;

    // RV64I major opcodes (instruction bits [6:0])
    localparam logic [6:0] OP        = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_32     = 7'b0111011;
    localparam logic [6:0] OP_IMM_32 = 7'b0011011;
    localparam logic [6:0] LOAD      = 7'b0000011;
    localparam logic [6:0] STORE     = 7'b0100011;
    localparam logic [6:0] LUI       = 7'b0110111;
    localparam logic [6:0] AUIPC     = 7'b0010111;
    localparam logic [6:0] JAL       = 7'b1101111;
    localparam logic [6:0] JALR      = 7'b1100111;
    localparam logic [6:0] BRANCH    = 7'b1100011;
    localparam logic [6:0] MISC_MEM  = 7'b0001111;
    localparam logic [6:0] SYSTEM    = 7'b1110011;

    // Load funct3 encodings
    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LD  = 3'b011;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_LWU = 3'b110;

    // Writeback stage states
    typedef enum logic [0:0] {
        IDLE      = 1'b0,
        WAIT_LOAD = 1'b1
    } wb_state_e;

endpackage
`default_nettype wire

// File: rtl/cprv_load_extract.sv
`default_nettype none
// ============================================================================
//  Module      : cprv_load_extract
//  Description : Combinational load data extraction. Shifts the aligned
//                memory word right by the byte offset, then sign- or
//                zero-extends according to funct3, and flags misalignment.
//  Revision    : 1.0 - initial release
//
//  Ports:
//    funct3_i      in   3           load funct3
//    offset_i      in   3           byte offset (effective address [2:0])
//    rdata_i       in   DATA_WIDTH  aligned memory word
//    data_o        out  DATA_WIDTH  extracted / extended load result
//    misaligned_o  out  1           access crosses its natural alignment
//    legal_o       out  1           funct3 is a load supported at this XLEN
// ============================================================================
module cprv_load_extract
    import cprv_pkg::*;
#(
    parameter int DATA_WIDTH = 64
) (
    input  logic [2:0]            funct3_i,
    input  logic [2:0]            offset_i,
    input  logic [DATA_WIDTH-1:0] rdata_i,
    output logic [DATA_WIDTH-1:0] data_o,
    output logic                  misaligned_o,
    output logic                  legal_o
);

    localparam bit IS64 = (DATA_WIDTH == 64);

    // A 32-bit memory word only has four byte lanes, so bit 2 of the
    // offset is meaningless there and is dropped.
    logic [2:0]            w_off;
    logic [DATA_WIDTH-1:0] w_shifted;

    assign w_off     = offset_i & 3'(DATA_WIDTH / 8 - 1);
    assign w_shifted = rdata_i >> {w_off, 3'b000};

    always_comb begin
        data_o       = '0;
        misaligned_o = 1'b0;
        legal_o      = 1'b0;
        unique case (funct3_i)
            F3_LB: begin
                legal_o = 1'b1;
                data_o  = DATA_WIDTH'($signed(w_shifted[7:0]));
            end
            F3_LBU: begin
                legal_o = 1'b1;
                data_o  = DATA_WIDTH'(w_shifted[7:0]);
            end
            F3_LH: begin
                legal_o      = 1'b1;
                misaligned_o = w_off[0];
                data_o       = DATA_WIDTH'($signed(w_shifted[15:0]));
            end
            F3_LHU: begin
                legal_o      = 1'b1;
                misaligned_o = w_off[0];
                data_o       = DATA_WIDTH'(w_shifted[15:0]);
            end
            F3_LW: begin
                legal_o      = 1'b1;
                misaligned_o = |w_off[1:0];
                data_o       = DATA_WIDTH'($signed(w_shifted[31:0]));
            end
            F3_LWU: begin
                legal_o      = IS64;
                misaligned_o = |w_off[1:0];
                data_o       = DATA_WIDTH'(w_shifted[31:0]);
            end
            F3_LD: begin
                legal_o      = IS64;
                misaligned_o = |w_off;
                data_o       = w_shifted;
            end
            default: begin
                legal_o = 1'b0;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/cprv_wb_commit.sv
`default_nettype none
// ============================================================================
//  Module      : cprv_wb_commit
//  Description : Writeback/commit stage. Accepts one instruction per
//                valid/ready handshake, selects and extends the result for
//                every RV64I writeback class, waits (with timeout) for late
//                load data, drives a registered register-file write port
//                that doubles as the forwarding source, and counts retired
//                instructions.
//  Revision    : 1.0 - initial release
//
//  Ports:
//    clk, rst_n           clock, asynchronous active-low reset
//    valid_wb_i/ready_wb_o  handshake with the mem stage
//    opcode/funct3/rd_addr/rd_en/imm/pc/alu_out _wb_i  instruction fields
//    rdata_wb_i, rdata_valid_wb_i  load data return
//    flush_i              abandon a pending load
//    rd_we_o/rd_addr_o/rd_data_o  register-file write / forwarding port
//    retire_o             one-cycle pulse per committed instruction
//    load_err_o           one-cycle pulse on load timeout or misalignment
//    instret_o            retired-instruction counter
// ============================================================================
module cprv_wb_commit
    import cprv_pkg::*;
#(
    parameter int DATA_WIDTH   = 64,
    parameter int WORD_WIDTH   = 32,
    parameter int LOAD_TIMEOUT = 64,
    parameter int CNT_WIDTH    = 64
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  valid_wb_i,
    output logic                  ready_wb_o,
    input  logic [6:0]            opcode_wb_i,
    input  logic [2:0]            funct3_wb_i,
    input  logic [4:0]            rd_addr_wb_i,
    input  logic                  rd_en_wb_i,
    input  logic [WORD_WIDTH-1:0] imm_data_wb_i,
    input  logic [DATA_WIDTH-1:0] pc_wb_i,
    input  logic [DATA_WIDTH-1:0] alu_out_wb_i,
    input  logic [DATA_WIDTH-1:0] rdata_wb_i,
    input  logic                  rdata_valid_wb_i,
    input  logic                  flush_i,
    output logic                  rd_we_o,
    output logic [4:0]            rd_addr_o,
    output logic [DATA_WIDTH-1:0] rd_data_o,
    output logic                  retire_o,
    output logic                  load_err_o,
    output logic [CNT_WIDTH-1:0]  instret_o
);

    localparam bit IS64 = (DATA_WIDTH == 64);
    localparam int TCW  = (LOAD_TIMEOUT > 1) ? $clog2(LOAD_TIMEOUT) : 1;

    // ------------------------------------------------------------------
    // State and captured load context
    // ------------------------------------------------------------------
    wb_state_e             state_q, state_d;
    logic [TCW-1:0]        tcnt_q, tcnt_d;
    logic [2:0]            ld_f3_q;
    logic [2:0]            ld_off_q;
    logic [4:0]            ld_rd_q;
    logic                  ld_rd_en_q;

    // Commit register outputs
    logic                  rd_we_q;
    logic [4:0]            rd_addr_q;
    logic [DATA_WIDTH-1:0] rd_data_q;
    logic                  retire_q;
    logic                  load_err_q;
    logic [CNT_WIDTH-1:0]  instret_q;

    // Next-state commit controls
    logic                  commit_d;
    logic                  we_d;
    logic [4:0]            addr_d;
    logic [DATA_WIDTH-1:0] data_d;
    logic                  err_d;
    logic                  capture_d;

    logic                  accept;
    logic                  is_load;
    logic [2:0]            ex_f3;
    logic [2:0]            ex_off;
    logic [DATA_WIDTH-1:0] ex_data;
    logic                  ex_mis;
    logic                  ex_legal;
    logic [DATA_WIDTH-1:0] res;
    logic                  res_writes;

    assign ready_wb_o = (state_q == IDLE);
    assign accept     = valid_wb_i & ready_wb_o;
    assign is_load    = (opcode_wb_i == LOAD);

    // The extractor looks at the incoming instruction while idle and at
    // the captured load context while waiting for data.
    assign ex_f3  = (state_q == IDLE) ? funct3_wb_i       : ld_f3_q;
    assign ex_off = (state_q == IDLE) ? alu_out_wb_i[2:0] : ld_off_q;

    cprv_load_extract #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_load_extract (
        .funct3_i     (ex_f3),
        .offset_i     (ex_off),
        .rdata_i      (rdata_wb_i),
        .data_o       (ex_data),
        .misaligned_o (ex_mis),
        .legal_o      (ex_legal)
    );

    // ------------------------------------------------------------------
    // Result select for an instruction committing straight from IDLE
    // ------------------------------------------------------------------
    always_comb begin
        res        = '0;
        res_writes = 1'b0;
        unique case (opcode_wb_i)
            OP, OP_IMM, AUIPC: begin
                res        = alu_out_wb_i;
                res_writes = 1'b1;
            end
            OP_32, OP_IMM_32: begin
                // Word ops only exist when XLEN is 64.
                res        = DATA_WIDTH'($signed(alu_out_wb_i[31:0]));
                res_writes = IS64;
            end
            LUI: begin
                res        = DATA_WIDTH'($signed(imm_data_wb_i));
                res_writes = 1'b1;
            end
            JAL, JALR: begin
                res        = pc_wb_i + DATA_WIDTH'(4);
                res_writes = 1'b1;
            end
            LOAD: begin
                res        = ex_data;
                res_writes = ex_legal & ~ex_mis;
            end
            STORE, BRANCH, MISC_MEM, SYSTEM: begin
                res_writes = 1'b0;
            end
            default: begin
                res_writes = 1'b0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Next-state / commit decision
    // ------------------------------------------------------------------
    always_comb begin
        state_d   = state_q;
        tcnt_d    = tcnt_q;
        commit_d  = 1'b0;
        we_d      = 1'b0;
        addr_d    = rd_addr_wb_i;
        data_d    = res;
        err_d     = 1'b0;
        capture_d = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    // Only a legal, aligned load whose data is not already
                    // here has to wait; everything else commits next cycle.
                    if (is_load && ex_legal && !ex_mis && !rdata_valid_wb_i) begin
                        state_d   = WAIT_LOAD;
                        tcnt_d    = '0;
                        capture_d = 1'b1;
                    end else begin
                        commit_d = 1'b1;
                        we_d     = rd_en_wb_i & (rd_addr_wb_i != 5'd0) & res_writes;
                        err_d    = is_load & ex_legal & ex_mis;
                    end
                end
            end
            WAIT_LOAD: begin
                if (flush_i) begin
                    state_d = IDLE;
                end else if (rdata_valid_wb_i) begin
                    state_d  = IDLE;
                    commit_d = 1'b1;
                    we_d     = ld_rd_en_q & (ld_rd_q != 5'd0);
                    addr_d   = ld_rd_q;
                    data_d   = ex_data;
                end else if (tcnt_q == TCW'(LOAD_TIMEOUT - 1)) begin
                    state_d  = IDLE;
                    commit_d = 1'b1;
                    err_d    = 1'b1;
                end else begin
                    tcnt_d = tcnt_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            tcnt_q     <= '0;
            ld_f3_q    <= '0;
            ld_off_q   <= '0;
            ld_rd_q    <= '0;
            ld_rd_en_q <= 1'b0;
            rd_we_q    <= 1'b0;
            rd_addr_q  <= '0;
            rd_data_q  <= '0;
            retire_q   <= 1'b0;
            load_err_q <= 1'b0;
            instret_q  <= '0;
        end else begin
            state_q    <= state_d;
            tcnt_q     <= tcnt_d;
            rd_we_q    <= we_d;
            retire_q   <= commit_d;
            load_err_q <= err_d;
            if (capture_d) begin
                ld_f3_q    <= funct3_wb_i;
                ld_off_q   <= alu_out_wb_i[2:0];
                ld_rd_q    <= rd_addr_wb_i;
                ld_rd_en_q <= rd_en_wb_i;
            end
            // Address/data only move on a real write so the forwarding
            // port keeps presenting the last written value afterwards.
            if (we_d) begin
                rd_addr_q <= addr_d;
                rd_data_q <= data_d;
            end
            if (commit_d) begin
                instret_q <= instret_q + CNT_WIDTH'(1);
            end
        end
    end

    assign rd_we_o    = rd_we_q;
    assign rd_addr_o  = rd_addr_q;
    assign rd_data_o  = rd_data_q;
    assign retire_o   = retire_q;
    assign load_err_o = load_err_q;
    assign instret_o  = instret_q;

endmodule
`default_nettype wire

// File: tb/tb_cprv_wb_commit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_cprv_wb_commit
//  Description : Scoreboard bench for cprv_wb_commit. Stimulus pushes the
//                expected commit of each instruction; a negedge monitor pops
//                and compares whenever the stage retires.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_cprv_wb_commit;

    localparam int DW = 64;
    localparam int WW = 32;
    localparam int LT = 4;
    localparam int CW = 64;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          valid_wb_i = 1'b0;
    logic          ready_wb_o;
    logic [6:0]    opcode_wb_i = '0;
    logic [2:0]    funct3_wb_i = '0;
    logic [4:0]    rd_addr_wb_i = '0;
    logic          rd_en_wb_i = 1'b0;
    logic [WW-1:0] imm_data_wb_i = '0;
    logic [DW-1:0] pc_wb_i = '0;
    logic [DW-1:0] alu_out_wb_i = '0;
    logic [DW-1:0] rdata_wb_i = '0;
    logic          rdata_valid_wb_i = 1'b0;
    logic          flush_i = 1'b0;
    logic          rd_we_o;
    logic [4:0]    rd_addr_o;
    logic [DW-1:0] rd_data_o;
    logic          retire_o;
    logic          load_err_o;
    logic [CW-1:0] instret_o;

    always #5 clk = ~clk;

    cprv_wb_commit #(
        .DATA_WIDTH   (DW),
        .WORD_WIDTH   (WW),
        .LOAD_TIMEOUT (LT),
        .CNT_WIDTH    (CW)
    ) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .valid_wb_i       (valid_wb_i),
        .ready_wb_o       (ready_wb_o),
        .opcode_wb_i      (opcode_wb_i),
        .funct3_wb_i      (funct3_wb_i),
        .rd_addr_wb_i     (rd_addr_wb_i),
        .rd_en_wb_i       (rd_en_wb_i),
        .imm_data_wb_i    (imm_data_wb_i),
        .pc_wb_i          (pc_wb_i),
        .alu_out_wb_i     (alu_out_wb_i),
        .rdata_wb_i       (rdata_wb_i),
        .rdata_valid_wb_i (rdata_valid_wb_i),
        .flush_i          (flush_i),
        .rd_we_o          (rd_we_o),
        .rd_addr_o        (rd_addr_o),
        .rd_data_o        (rd_data_o),
        .retire_o         (retire_o),
        .load_err_o       (load_err_o),
        .instret_o        (instret_o)
    );

    typedef struct packed {
        logic        we;
        logic [4:0]  addr;
        logic [63:0] data;
        logic        err;
        logic [63:0] instret;
    } exp_t;

    exp_t        exp_q[$];
    int          vectors = 0;
    int          miscompares = 0;
    logic [63:0] exp_instret = '0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s: got %h, required %h", name, act, req);
        end
    endtask

    task automatic expect_commit(input logic we, input logic [4:0] addr,
                                 input logic [63:0] data, input logic err);
        exp_t e;
        exp_instret = exp_instret + 64'd1;
        e.we      = we;
        e.addr    = addr;
        e.data    = data;
        e.err     = err;
        e.instret = exp_instret;
        exp_q.push_back(e);
    endtask

    // Present one instruction for exactly one accepting edge.
    task automatic issue(input logic [6:0] opc, input logic [2:0] f3, input logic [4:0] rd,
                         input logic rd_en, input logic [31:0] imm, input logic [63:0] pc,
                         input logic [63:0] alu, input logic [63:0] rdata, input logic rvalid);
        opcode_wb_i      = opc;
        funct3_wb_i      = f3;
        rd_addr_wb_i     = rd;
        rd_en_wb_i       = rd_en;
        imm_data_wb_i    = imm;
        pc_wb_i          = pc;
        alu_out_wb_i     = alu;
        rdata_wb_i       = rdata;
        rdata_valid_wb_i = rvalid;
        valid_wb_i       = 1'b1;
        check("ready_at_issue", {63'd0, ready_wb_o}, 64'd1);
        @(posedge clk); #1;
        valid_wb_i       = 1'b0;
        rdata_valid_wb_i = 1'b0;
    endtask

    // Load that waits: ready must be low for four cycles; data (if any)
    // arrives in the fourth waiting cycle, the same cycle the timeout
    // counter reaches its last value.
    task automatic load_late(input logic [2:0] f3, input logic [4:0] rd, input logic [63:0] alu,
                             input logic give_data, input logic [63:0] rdata);
        issue(7'b0000011, f3, rd, 1'b1, 32'd0, 64'd0, alu, 64'd0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            check("ready_low_in_wait", {63'd0, ready_wb_o}, 64'd0);
            if (i < 3) begin
                @(posedge clk); #1;
            end
        end
        rdata_wb_i       = rdata;
        rdata_valid_wb_i = give_data;
        @(posedge clk); #1;
        rdata_valid_wb_i = 1'b0;
        check("ready_after_wait", {63'd0, ready_wb_o}, 64'd1);
    endtask

    // ------------------------------------------------------------------
    // Monitor
    // ------------------------------------------------------------------
    exp_t        mon_e;
    logic        prev_ret = 1'b0;
    logic [4:0]  prev_addr = '0;
    logic [63:0] prev_data = '0;

    always @(negedge clk) begin
        if (rst_n) begin
            if (retire_o) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_retire", {63'd0, retire_o}, 64'd0);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("rd_we", {63'd0, rd_we_o}, {63'd0, mon_e.we});
                    check("load_err", {63'd0, load_err_o}, {63'd0, mon_e.err});
                    check("instret", instret_o, mon_e.instret);
                    if (mon_e.we) begin
                        check("rd_addr", {59'd0, rd_addr_o}, {59'd0, mon_e.addr});
                        check("rd_data", rd_data_o, mon_e.data);
                    end
                end
            end else begin
                if (rd_we_o || load_err_o) begin
                    check("stray_we", {63'd0, rd_we_o}, 64'd0);
                    check("stray_err", {63'd0, load_err_o}, 64'd0);
                end
                if (prev_ret) begin
                    check("we_drop", {63'd0, rd_we_o}, 64'd0);
                    check("addr_hold", {59'd0, rd_addr_o}, {59'd0, prev_addr});
                    check("data_hold", rd_data_o, prev_data);
                end
            end
            prev_ret  = retire_o;
            prev_addr = rd_addr_o;
            prev_data = rd_data_o;
        end else begin
            prev_ret = 1'b0;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1, "watchdog");
    end

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    initial begin
        repeat (2) @(posedge clk);
        #1;
        check("rst_ready", {63'd0, ready_wb_o}, 64'd1);
        check("rst_we", {63'd0, rd_we_o}, 64'd0);
        check("rst_retire", {63'd0, retire_o}, 64'd0);
        check("rst_instret", instret_o, 64'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("post_rst_data", rd_data_o, 64'd0);

        // Main function: every writing class
        expect_commit(1'b1, 5'd5, 64'hFFFF_FFFF_8000_0000, 1'b0);
        issue(7'b0110011, 3'd0, 5'd5, 1'b1, 32'd0, 64'd0, 64'hFFFF_FFFF_8000_0000, 64'd0, 1'b0);
        expect_commit(1'b1, 5'd6, 64'hFFFF_FFFF_8000_0001, 1'b0);
        issue(7'b0111011, 3'd0, 5'd6, 1'b1, 32'd0, 64'd0, 64'h0000_0000_8000_0001, 64'd0, 1'b0);
        expect_commit(1'b1, 5'd7, 64'h0000_0000_1234_5678, 1'b0);
        issue(7'b0011011, 3'd0, 5'd7, 1'b1, 32'd0, 64'd0, 64'hDEAD_BEEF_1234_5678, 64'd0, 1'b0);
        expect_commit(1'b1, 5'd1, 64'h0000_0000_0000_1004, 1'b0);
        issue(7'b1101111, 3'd0, 5'd1, 1'b1, 32'd0, 64'h1000, 64'h5555, 64'd0, 1'b0);
        expect_commit(1'b1, 5'd2, 64'h0, 1'b0);
        issue(7'b1100111, 3'd0, 5'd2, 1'b1, 32'd0, 64'hFFFF_FFFF_FFFF_FFFC, 64'h5555, 64'd0, 1'b0);
        expect_commit(1'b1, 5'd8, 64'hFFFF_FFFF_8000_0000, 1'b0);
        issue(7'b0110111, 3'd0, 5'd8, 1'b1, 32'h8000_0000, 64'd0, 64'h5555, 64'd0, 1'b0);
        expect_commit(1'b1, 5'd9, 64'h0000_1234_0000_0000, 1'b0);
        issue(7'b0010111, 3'd0, 5'd9, 1'b1, 32'd0, 64'd0, 64'h0000_1234_0000_0000, 64'd0, 1'b0);
        expect_commit(1'b1, 5'd31, 64'h7, 1'b0);
        issue(7'b0010011, 3'd0, 5'd31, 1'b1, 32'd0, 64'd0, 64'h7, 64'd0, 1'b0);

        // Loads with data on the accept cycle
        expect_commit(1'b1, 5'd13, 64'h1234_5678_9ABC_DEF0, 1'b0);
        issue(7'b0000011, 3'b011, 5'd13, 1'b1, 32'd0, 64'd0, 64'h100, 64'h1234_5678_9ABC_DEF0, 1'b1);
        expect_commit(1'b1, 5'd14, 64'h8765, 1'b0);
        issue(7'b0000011, 3'b101, 5'd14, 1'b1, 32'd0, 64'd0, 64'h106, 64'h8765_0000_0000_0000, 1'b1);
        expect_commit(1'b1, 5'd15, 64'hFFFF_FFFF_8000_0000, 1'b0);
        issue(7'b0000011, 3'b010, 5'd15, 1'b1, 32'd0, 64'd0, 64'h104, 64'h8000_0000_0000_0000, 1'b1);
        expect_commit(1'b1, 5'd16, 64'h0000_0000_8000_0000, 1'b0);
        issue(7'b0000011, 3'b110, 5'd16, 1'b1, 32'd0, 64'd0, 64'h104, 64'h8000_0000_0000_0000, 1'b1);
        expect_commit(1'b1, 5'd17, 64'hFFFF_FFFF_FFFF_8001, 1'b0);
        issue(7'b0000011, 3'b001, 5'd17, 1'b1, 32'd0, 64'd0, 64'h2, 64'h0000_0000_8001_0000, 1'b1);

        // Late loads (data in the last waiting cycle beats the timeout)
        expect_commit(1'b1, 5'd11, 64'hFFFF_FFFF_FFFF_FFF0, 1'b0);
        load_late(3'b000, 5'd11, 64'h1003, 1'b1, 64'h0000_0000_F000_0000);
        expect_commit(1'b1, 5'd12, 64'h0000_0000_0000_00F0, 1'b0);
        load_late(3'b100, 5'd12, 64'h1003, 1'b1, 64'h0000_0000_F000_0000);

        // Misaligned loads commit at once with an error and no write
        expect_commit(1'b0, 5'd0, 64'd0, 1'b1);
        issue(7'b0000011, 3'b010, 5'd18, 1'b1, 32'd0, 64'd0, 64'h2, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1);
        expect_commit(1'b0, 5'd0, 64'd0, 1'b1);
        issue(7'b0000011, 3'b001, 5'd19, 1'b1, 32'd0, 64'd0, 64'h1, 64'd0, 1'b0);

        // Timeout
        expect_commit(1'b0, 5'd0, 64'd0, 1'b1);
        load_late(3'b011, 5'd20, 64'h2000, 1'b0, 64'd0);

        // Flush wins over simultaneous data
        issue(7'b0000011, 3'b011, 5'd10, 1'b1, 32'd0, 64'd0, 64'h3000, 64'd0, 1'b0);
        flush_i          = 1'b1;
        rdata_valid_wb_i = 1'b1;
        rdata_wb_i       = 64'hAAAA_BBBB_CCCC_DDDD;
        @(posedge clk); #1;
        flush_i          = 1'b0;
        rdata_valid_wb_i = 1'b0;
        check("flush_ready", {63'd0, ready_wb_o}, 64'd1);
        check("flush_no_retire", {63'd0, retire_o}, 64'd0);
        check("flush_no_we", {63'd0, rd_we_o}, 64'd0);

        // Non-writing commits
        expect_commit(1'b0, 5'd0, 64'd0, 1'b0);
        issue(7'b0110011, 3'd0, 5'd0, 1'b1, 32'd0, 64'd0, 64'h1234, 64'd0, 1'b0);
        expect_commit(1'b0, 5'd0, 64'd0, 1'b0);
        issue(7'b0100011, 3'd0, 5'd21, 1'b1, 32'd0, 64'd0, 64'h1234, 64'd0, 1'b0);
        expect_commit(1'b0, 5'd0, 64'd0, 1'b0);
        issue(7'b1100011, 3'd0, 5'd22, 1'b1, 32'd0, 64'd0, 64'h1234, 64'd0, 1'b0);
        expect_commit(1'b0, 5'd0, 64'd0, 1'b0);
        issue(7'b0110011, 3'd0, 5'd4, 1'b0, 32'd0, 64'd0, 64'h1234, 64'd0, 1'b0);
        @(posedge clk); #1;

        // Asynchronous reset while waiting for a load
        issue(7'b0000011, 3'b011, 5'd23, 1'b1, 32'd0, 64'd0, 64'h4000, 64'd0, 1'b0);
        @(posedge clk); #2;
        rst_n = 1'b0;
        #1;
        check("arst_ready", {63'd0, ready_wb_o}, 64'd1);
        check("arst_we", {63'd0, rd_we_o}, 64'd0);
        check("arst_addr", {59'd0, rd_addr_o}, 64'd0);
        check("arst_data", rd_data_o, 64'd0);
        check("arst_retire", {63'd0, retire_o}, 64'd0);
        check("arst_err", {63'd0, load_err_o}, 64'd0);
        check("arst_instret", instret_o, 64'd0);
        exp_q.delete();
        exp_instret = '0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        expect_commit(1'b1, 5'd3, 64'hCAFE, 1'b0);
        issue(7'b0110011, 3'd0, 5'd3, 1'b1, 32'd0, 64'd0, 64'hCAFE, 64'd0, 1'b0);

        repeat (3) @(posedge clk);
        #1;
        check("scoreboard_drained", 64'(exp_q.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
